// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StGreen  = 3'd1,
        StYellow = 3'd2,
        StAllred = 3'd3,
        StEmerg  = 3'd4
    } phase_e;

    localparam logic [2:0] LampR = 3'b001;
    localparam logic [2:0] LampY = 3'b010;
    localparam logic [2:0] LampG = 3'b100;

    // Width of a road index; never narrower than one bit.
    function automatic int unsigned road_width(input int unsigned roads);
        return (roads > 1) ? $clog2(roads) : 1;
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_timer.sv
// Loadable down-counter shared by every timed phase; holds at zero.
module phase_timer #(
    parameter int unsigned Width = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    output logic [Width-1:0] value,
    output logic             zero
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-road traffic light controller: FSM, road pointer, pedestrian latches and lamp decode.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned ROADS     = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned PED_EXTRA = 3,
    localparam int unsigned RoadW    = road_width(ROADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [ROADS*CNT_W-1:0] green_time,
    input  logic [CNT_W-1:0]       yellow_time,
    input  logic [CNT_W-1:0]       allred_time,
    input  logic [ROADS-1:0]       ped_req,
    input  logic                   emerg_req,
    input  logic [RoadW-1:0]       emerg_road,
    output logic [3*ROADS-1:0]     lamps,
    output logic [ROADS-1:0]       ped_walk,
    output logic [RoadW-1:0]       active_road,
    output logic [2:0]             phase
);

    localparam int unsigned TW = CNT_W + 1;

    phase_e           state_q, state_d;
    logic [RoadW-1:0] road_q, road_d;
    logic [ROADS-1:0] pend_q, pend_d;
    logic             grant_q, grant_d;

    logic             tmr_load;
    logic [TW-1:0]    tmr_load_value;
    logic [TW-1:0]    tmr_value;
    logic             tmr_zero;
    logic             expired;

    logic [CNT_W-1:0] green_sel;
    logic [TW-1:0]    green_total;
    logic [RoadW-1:0] road_next;

    // A duration of T (0 treated as 1) runs for exactly max(T,1) cycles.
    function automatic logic [TW-1:0] load_for(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    phase_timer #(
        .Width(TW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_value(tmr_load_value),
        .value     (tmr_value),
        .zero      (tmr_zero)
    );

    assign expired     = tmr_zero && (tmr_value == '0);
    assign green_sel   = green_time[road_q*CNT_W +: CNT_W];
    assign green_total = TW'(green_sel) + (pend_q[road_q] ? TW'(PED_EXTRA) : '0);
    assign road_next   = (road_q == RoadW'(ROADS - 1)) ? '0 : road_q + RoadW'(1);

    always_comb begin
        state_d        = state_q;
        road_d         = road_q;
        pend_d         = pend_q | ped_req;
        grant_d        = grant_q;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d        = StAllred;
                    road_d         = '0;
                    tmr_load       = 1'b1;
                    tmr_load_value = load_for(TW'(allred_time));
                end
            end
            StAllred: begin
                if (expired) begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (emerg_req) begin
                        state_d = StEmerg;
                        road_d  = emerg_road;
                    end else begin
                        // Granting clears this road's latch even against a same-cycle press.
                        state_d        = StGreen;
                        grant_d        = pend_q[road_q];
                        pend_d[road_q] = 1'b0;
                        tmr_load       = 1'b1;
                        tmr_load_value = load_for(green_total);
                    end
                end
            end
            StGreen: begin
                if (emerg_req && (road_q == emerg_road)) begin
                    state_d = StEmerg;
                    grant_d = 1'b0;
                end else if (emerg_req || !enable || expired) begin
                    state_d        = StYellow;
                    grant_d        = 1'b0;
                    tmr_load       = 1'b1;
                    tmr_load_value = load_for(TW'(yellow_time));
                end
            end
            StYellow: begin
                if (expired) begin
                    state_d        = StAllred;
                    road_d         = road_next;
                    tmr_load       = 1'b1;
                    tmr_load_value = load_for(TW'(allred_time));
                end
            end
            StEmerg: begin
                if (!emerg_req) begin
                    state_d        = StYellow;
                    tmr_load       = 1'b1;
                    tmr_load_value = load_for(TW'(yellow_time));
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            road_q  <= '0;
            pend_q  <= '0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            road_q  <= road_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        lamps    = {ROADS{LampR}};
        ped_walk = '0;
        for (int unsigned r = 0; r < ROADS; r++) begin
            if (road_q == RoadW'(r)) begin
                if (state_q == StGreen || state_q == StEmerg) begin
                    lamps[3*r +: 3] = LampG;
                end else if (state_q == StYellow) begin
                    lamps[3*r +: 3] = LampY;
                end
                ped_walk[r] = grant_q && (state_q == StGreen);
            end
        end
    end

    assign active_road = road_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Randomized bench comparing the sequencer against a cycle-count reference model.
module tb_traffic_phase_sequencer;

    localparam int ROADS     = 4;
    localparam int CNT_W     = 4;
    localparam int PED_EXTRA = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] green_time;
    logic [3:0]  yellow_time;
    logic [3:0]  allred_time;
    logic [3:0]  ped_req;
    logic        emerg_req;
    logic [1:0]  emerg_road;
    logic [11:0] lamps;
    logic [3:0]  ped_walk;
    logic [1:0]  active_road;
    logic [2:0]  phase;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: phase code, served road, cycles left in the phase.
    int      m_phase;
    int      m_road;
    int      m_left;
    bit [3:0] m_pend;
    bit      m_grant;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .ROADS    (ROADS),
        .CNT_W    (CNT_W),
        .PED_EXTRA(PED_EXTRA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .green_time (green_time),
        .yellow_time(yellow_time),
        .allred_time(allred_time),
        .ped_req    (ped_req),
        .emerg_req  (emerg_req),
        .emerg_road (emerg_road),
        .lamps      (lamps),
        .ped_walk   (ped_walk),
        .active_road(active_road),
        .phase      (phase)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dur(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int green_field(input int r);
        return int'((green_time >> (CNT_W * r)) & 16'hf);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_road  = 0;
        m_left  = 0;
        m_pend  = '0;
        m_grant = 1'b0;
    endtask

    task automatic model_step();
        bit [3:0] pend_next;
        pend_next = m_pend | ped_req;
        case (m_phase)
            0: if (enable) begin
                m_phase = 3;
                m_road  = 0;
                m_left  = dur(int'(allred_time));
            end
            3: begin
                if (m_left > 1) m_left--;
                else if (!enable) m_phase = 0;
                else if (emerg_req) begin
                    m_phase = 4;
                    m_road  = int'(emerg_road);
                end else begin
                    m_grant = m_pend[m_road];
                    m_left  = dur(green_field(m_road) + (m_grant ? PED_EXTRA : 0));
                    pend_next[m_road] = 1'b0;
                    m_phase = 1;
                end
            end
            1: begin
                if (emerg_req && m_road == int'(emerg_road)) begin
                    m_phase = 4;
                    m_grant = 1'b0;
                end else if (emerg_req || !enable || m_left == 1) begin
                    m_phase = 2;
                    m_grant = 1'b0;
                    m_left  = dur(int'(yellow_time));
                end else m_left--;
            end
            2: begin
                if (m_left > 1) m_left--;
                else begin
                    m_phase = 3;
                    m_road  = (m_road + 1) % ROADS;
                    m_left  = dur(int'(allred_time));
                end
            end
            4: if (!emerg_req) begin
                m_phase = 2;
                m_left  = dur(int'(yellow_time));
            end
            default: m_phase = 0;
        endcase
        m_pend = pend_next;
    endtask

    task automatic check_outputs();
        logic [11:0] exp_l;
        logic [3:0]  exp_w;
        exp_l = {4{3'b001}};
        exp_w = '0;
        if (m_phase == 1 || m_phase == 4) exp_l[3*m_road +: 3] = 3'b100;
        if (m_phase == 2) exp_l[3*m_road +: 3] = 3'b010;
        if (m_phase == 1 && m_grant) exp_w[m_road] = 1'b1;
        check("phase", 32'(phase), m_phase);
        check("lamps", 32'(lamps), 32'(exp_l));
        check("walk", 32'(ped_walk), 32'(exp_w));
        check("road", 32'(active_road), m_road);
    endtask

    // Inputs are already driven for the coming edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_for(input int ph, input int rd, input int budget, input string tag);
        int n;
        n = 0;
        while (!(m_phase == ph && m_road == rd) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(phase) * 4 + 32'(active_road), ph * 4 + rd);
    endtask

    task automatic set_plan_timing();
        green_time  = {4'd4, 4'd3, 4'd2, 4'd1};
        yellow_time = 4'd2;
        allred_time = 4'd1;
    endtask

    initial begin
        int walk_cycles;
        int eh;
        reset      = 1'b0;
        enable     = 1'b0;
        ped_req    = '0;
        emerg_req  = 1'b0;
        emerg_road = '0;
        set_plan_timing();
        repeat (2) @(negedge clk);
        model_reset();
        check_outputs();
        reset = 1'b1;

        // Basic rotation with the plan timing.
        enable = 1'b1;
        repeat (40) tick();

        // Pedestrian pulse for road 1 while road 0 is green.
        wait_for(1, 0, 80, "wait_g0_ped");
        ped_req = 4'b0010;
        tick();
        ped_req = '0;
        walk_cycles = 0;
        repeat (60) begin
            tick();
            if (ped_walk[1]) walk_cycles++;
        end
        check("walk_len", walk_cycles, 2 + PED_EXTRA);

        // Preempt to road 2 while road 0 is green.
        green_time = {4'd4, 4'd3, 4'd2, 4'd5};
        wait_for(1, 0, 80, "wait_g0_emerg");
        emerg_req  = 1'b1;
        emerg_road = 2'd2;
        repeat (15) tick();
        check("emerg_hold", 32'(phase) * 4 + 32'(active_road), 4 * 4 + 2);
        emerg_req = 1'b0;
        repeat (20) tick();

        // All timing fields zero.
        green_time  = '0;
        yellow_time = '0;
        allred_time = '0;
        repeat (30) begin
            ped_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            tick();
        end

        // Random traffic.
        eh = 0;
        repeat (3000) begin
            enable = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 7) == 0) begin
                green_time  = 16'($urandom);
                yellow_time = 4'($urandom_range(0, 5));
                allred_time = 4'($urandom_range(0, 4));
            end
            ped_req    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            emerg_road = 2'($urandom_range(0, 3));
            if (eh > 0) eh--;
            else if ($urandom_range(0, 79) == 0) eh = $urandom_range(1, 15);
            emerg_req = (eh > 0);
            tick();
        end

        // Asynchronous reset in the middle of a preempt.
        enable     = 1'b1;
        ped_req    = '0;
        set_plan_timing();
        emerg_req  = 1'b1;
        emerg_road = 2'd1;
        wait_for(4, 1, 80, "wait_emerg");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_phase", 32'(phase), 0);
        check("rst_lamps", 32'(lamps), 32'h249);
        check("rst_walk", 32'(ped_walk), 0);
        check("rst_road", 32'(active_road), 0);
        model_reset();
        emerg_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Self-contained traffic-light controller for N roads. It merges the control FSM and the timing datapath into one block. Each road cycles GREEN -> YELLOW -> ALL-RED clearance before the next road. Per-road green times, pedestrian walk extension and an emergency-preempt override are supported. The block sits between the timing-configuration registers and the lamp drivers.

## Interface

Parameters:
- ROADS, 4, number of roads (>= 2)
- CNT_W, 4, width of each timing field
- PED_EXTRA, 3, extra green cycles granted for a pedestrian request (<= 2^CNT_W-1)

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; low parks the controller all-red
- green_time  in  ROADS*CNT_W  per-road green duration; field r = bits [r*CNT_W +: CNT_W]
- yellow_time  in  CNT_W  yellow duration, shared by all roads
- allred_time  in  CNT_W  all-red clearance duration
- ped_req  in  ROADS  pedestrian button per road; level or pulse
- emerg_req  in  1  emergency preempt; level
- emerg_road  in  clog2(ROADS)  road to serve during preempt
- lamps  out  3*ROADS  per road {G,Y,R} one-hot; road r = bits [3r+2:3r]
- ped_walk  out  ROADS  walk signal; high only for the road in GREEN with a granted request
- active_road  out  clog2(ROADS)  road currently or next served
- phase  out  3  encoded state (IDLE=0, GREEN=1, YELLOW=2, ALLRED=3, EMERG=4)

## Operation

- State machine: IDLE, GREEN, YELLOW, ALLRED, EMERG.
- Down-counter width: CNT_W+1.
  - On entering a timed state it loads max(T,1)-1, where T is the duration sampled in that entry cycle.
  - A timed state therefore lasts exactly max(T,1) cycles.
  - The state exits on the cycle the counter is 0.
- IDLE: all lamps red.
  - Leaves IDLE when enable=1: goes to ALLRED with active_road=0.
- ALLRED: all lamps red. On expiry:
  - enable=0 -> IDLE.
  - Preempt pending -> EMERG.
  - Otherwise -> GREEN on active_road.
- GREEN: duration is green_time[active_road], plus PED_EXTRA if ped_pend[active_road] is set at entry.
  - At entry, ped_pend[active_road] is cleared and ped_grant is set.
  - ped_walk[active_road] = ped_grant during GREEN.
  - On expiry -> YELLOW.
- YELLOW: lasts yellow_time.
  - On expiry -> ALLRED.
  - active_road advances to (active_road+1) mod ROADS. Wrap is explicit: ROADS-1 -> 0, including non-power-of-2 ROADS.
- ped_pend[r] is set by ped_req[r]=1 in any cycle and held until granted.
  - Setting it has priority over clearing, except for the road being granted in that same entry cycle.
- Emergency preempt (emerg_req=1, latched target E):
  - In GREEN with active_road==E: go straight to EMERG, no yellow.
  - In GREEN with active_road!=E: truncate and go to YELLOW next cycle.
  - In YELLOW or ALLRED: finish normally.
  - ALLRED expiry: active_road := E and go to EMERG.
- EMERG: road E green, others red, ped_walk all 0. Held while emerg_req=1.
  - On deassert -> YELLOW on E. Sequencing then resumes at E+1.
  - emerg_road changes during EMERG are ignored.
- enable=0 handling:
  - In GREEN: truncate to YELLOW, then ALLRED, then IDLE.
  - In EMERG: the preempt has priority; enable is honoured after EMERG exits.
- A change to the timing inputs affects only the next state entry.

## Timing

- Values after reset assertion (asynchronous):
  - phase=IDLE, active_road=0, counter=0.
  - ped_pend=0, ped_grant=0.
  - lamps = all R (one-hot R per road), ped_walk=0.
- All outputs are registered or decoded only from registers; there is no combinational input-to-output path.
- Latency:
  - enable rise to ALLRED: 1 cycle.
  - emerg_req rise to leaving GREEN: 1 cycle.
  - ped_req to registered ped_pend: 1 cycle.
- Reset deasserted mid-sequence restarts from IDLE; no state is retained.

## Structure

- Shared package traffic_pkg:
  - phase encoding constants.
  - lamp one-hot constants (R=3'b001, Y=3'b010, G=3'b100).
  - clog2 helper usage.
- Sub-module phase_timer: loadable (CNT_W+1)-bit down-counter with load, value and zero flag, reused for all timed states.
- FSM, road pointer, pedestrian latches and lamp decode live in the top module.

## Test plan

- Reset then enable=1; green_time={4,3,2,1}, yellow=2, allred=1:
  - Expected order: road0 G for 1 cycle, Y 2, AR 1, road1 G 2 ... road3 G 4.
  - active_road wraps 3->0.
- ROADS=3, green=5: active_road sequence 0,1,2,0. It never reaches 3.
- ped_req[1] pulsed during road0 GREEN:
  - road1 GREEN lasts green_time[1]+3 cycles, with ped_walk[1] high for the whole period.
  - The next road1 GREEN has no extension.
- emerg_req=1, emerg_road=2, while road0 is in GREEN:
  - Next cycle YELLOW, then ALLRED, then EMERG with road2 G for as long as emerg_req is held.
  - After release: road2 Y, AR, then road3 GREEN.
- Timing fields of 0: every timed state lasts exactly 1 cycle.
- reset pulled low during EMERG: the same cycle shows all lamps red and phase=IDLE; the post-reset sequence is identical to the first scenario.
